// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock and ripples the carry
// between cycles. It uses valid/ready handshakes and allows one operation in flight.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_serial_adder: WIDTH must be an integer multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   partial_q, partial_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic               msb_carry_in;

  assign a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
  // The carry into the top bit can be recovered from the top bit's sum: s = a ^ b ^ cin.
  assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        partial_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = partial_d;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: operand and partial registers are left unreset because each accept reloads them before use.
  always_ff @(posedge clk) begin
    a_q       <= a_d;
    b_q       <= b_d;
    partial_q <= partial_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: WIDTH=8/CHUNK=2 directed cases and WIDTH=16/CHUNK=4 random traffic,
// both compared against an arithmetic model of a +/- b.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic        sel;  // 0: 8-bit instance, 1: 16-bit instance

  logic        rdy8, vld8, co8, ov8;
  logic [7:0]  s8;
  logic        rdy16, vld16, co16, ov16;
  logic [15:0] s16;

  logic        rdy, vld, co, ov;
  logic [15:0] s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(vld8), .out_ready(out_ready & ~sel),
    .sum(s8), .cout(co8), .overflow(ov8)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(rdy16),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(vld16), .out_ready(out_ready & sel),
    .sum(s16), .cout(co16), .overflow(ov16)
  );

  always_comb begin
    rdy = sel ? rdy16 : rdy8;
    vld = sel ? vld16 : vld8;
    s   = sel ? s16 : {8'h00, s8};
    co  = sel ? co16 : co8;
    ov  = sel ? ov16 : ov8;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Unsigned and signed views of a +/- b, evaluated in wide integer arithmetic.
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic sb,
                                output logic [15:0] es, output logic eco, output logic eov);
    longint m, ua, ub, r, sa, sbv, sr;
    m  = longint'(1) << w;
    ua = longint'(av) & (m - 1);
    ub = longint'(bv) & (m - 1);
    if (sb) begin
      r   = ua - ub;
      eco = (ua >= ub);
    end else begin
      r   = ua + ub + longint'(ci);
      eco = (r >= m);
    end
    es  = 16'(r & (m - 1));
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    sr  = sb ? sa - sbv : sa + sbv + longint'(ci);
    eov = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, input int gap, input int hold);
    int          w, lat;
    logic [15:0] es;
    logic        eco, eov;
    w = sel ? 16 : 8;
    model(w, av, bv, ci, sb, es, eco, eov);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    check("idle_in_ready", 32'(rdy), 1);
    check("idle_out_valid", 32'(vld), 0);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!vld && lat < 16) begin
      check("calc_in_ready", 32'(rdy), 0);
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("latency", 32'(lat), 4);
    check("done_in_ready", 32'(rdy), 0);
    check("sum", 32'(s), 32'(es));
    check("cout", 32'(co), 32'(eco));
    check("overflow", 32'(ov), 32'(eov));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(vld), 1);
      check("hold_in_ready", 32'(rdy), 0);
      check("hold_sum", 32'(s), 32'(es));
      check("hold_cout", 32'(co), 32'(eco));
      check("hold_overflow", 32'(ov), 32'(eov));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", 32'(rdy), 1);
    check("release_out_valid", 32'(vld), 0);
    check("release_sum_held", 32'(s), 32'(es));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cin = 1'b0; sub = 1'b0; a = '0; b = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = 1'(k);
      #0;
      check("rst_in_ready", 32'(rdy), 1);
      check("rst_out_valid", 32'(vld), 0);
      check("rst_sum", 32'(s), 0);
      check("rst_cout", 32'(co), 0);
      check("rst_overflow", 32'(ov), 0);
    end
    sel = 1'b0;
    rst = 1'b0;

    run_op(16'd200, 16'd100, 1'b0, 1'b0, 0, 0);
    check("tp_200p100_sum", 32'(s), 44);
    check("tp_200p100_cout", 32'(co), 1);
    check("tp_200p100_ovf", 32'(ov), 0);
    run_op(16'd100, 16'd100, 1'b0, 1'b0, 1, 0);
    check("tp_100p100_sum", 32'(s), 32'h00C8);
    check("tp_100p100_ovf", 32'(ov), 1);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0, 1);
    check("tp_ffp0c_sum", 32'(s), 0);
    check("tp_ffp0c_cout", 32'(co), 1);
    run_op(16'd5, 16'd7, 1'b1, 1'b1, 2, 0);
    check("tp_5m7_sum", 32'(s), 32'h00FE);
    check("tp_5m7_cout", 32'(co), 0);
    run_op(16'h0080, 16'h0001, 1'b0, 1'b1, 0, 0);
    check("tp_80m1_sum", 32'(s), 32'h007F);
    check("tp_80m1_cout", 32'(co), 1);
    check("tp_80m1_ovf", 32'(ov), 1);
    run_op(16'h0012, 16'h0034, 1'b0, 1'b0, 0, 10);

    // Abort an operation with reset during its second CALC cycle.
    a = 16'h00AA; b = 16'h0055; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(rdy), 1);
    check("abort_out_valid", 32'(vld), 0);
    check("abort_sum", 32'(s), 0);
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(vld), 0);
    end
    run_op(16'd3, 16'd4, 1'b0, 1'b0, 0, 0);
    check("after_abort_sum", 32'(s), 7);

    sel = 1'b1;
    for (int n = 0; n < 200; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
